// File: rtl/nav_pkg.sv
// Shared types and helpers for the navigation state integrator.
// FSM state encoding, command encoding and saturation limits.
package nav_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic CMD_SET  = 1'b1;
  localparam logic CMD_PROP = 1'b0;

  // Wide enough for any supported word width; callers truncate to their width.
  localparam int unsigned LIM_W = 128;

  // Largest representable signed value of a w-bit word.
  function automatic logic signed [LIM_W-1:0] sat_max(input int unsigned w);
    return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
  endfunction

  // Most negative representable signed value of a w-bit word.
  function automatic logic signed [LIM_W-1:0] sat_min(input int unsigned w);
    return -(LIM_W'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/nav_axis_mac.sv
// One-axis update: pos + ((vel * dt) >>> FRAC) with range detection.
// Build option NAV_SAT_EN: saturate out-of-range sums instead of wrapping.
module nav_axis_mac
  import nav_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DT_W  = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] pos,
  input  logic signed [WIDTH-1:0] vel,
  input  logic        [DT_W-1:0]  dt,
  output logic        [WIDTH-1:0] pos_next_c,
  output logic                    ovf_c
);

  localparam int unsigned PROD_W = WIDTH + DT_W + 1;
  localparam int unsigned SUM_W  = WIDTH + DT_W + 2;
  localparam int unsigned TOP_W  = SUM_W - WIDTH + 1;

  logic signed [DT_W:0]       dt_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   delta;
  logic signed [SUM_W-1:0]    sum;
  logic        [TOP_W-1:0]    top;

  // dt is unsigned: a zero sign bit keeps the product signed but correct
  assign dt_s  = {1'b0, dt};
  assign prod  = $signed(PROD_W'(vel)) * $signed(PROD_W'(dt_s));
  // Arithmetic shift floors toward minus infinity
  assign delta = prod >>> FRAC;
  assign sum   = $signed(SUM_W'(pos)) + $signed(SUM_W'(delta));

  // In range iff every bit from the result sign bit upward agrees
  assign top   = sum[SUM_W-1:WIDTH-1];
  assign ovf_c = !((&top) || !(|top));

`ifdef NAV_SAT_EN
  assign pos_next_c = ovf_c ? (sum[SUM_W-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH)))
                            : WIDTH'(sum);
`else
  assign pos_next_c = WIDTH'(sum);
`endif

endmodule

// File: rtl/nav_state_integrator.sv
// Per-axis position integrator: SET loads state, PROP adds (vel*dt)>>>FRAC
// serially through one shared MAC. Build option NAV_SAT_EN selects
// saturation (defined) or wrap (undefined) on overflow.
module nav_state_integrator
  import nav_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AXES  = 3,
  parameter int unsigned DT_W  = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    cmd_set,
  input  logic [AXES*WIDTH-1:0]   pos_in,
  input  logic [AXES*WIDTH-1:0]   vel_in,
  input  logic [DT_W-1:0]         dt_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AXES*WIDTH-1:0]   pos_out,
  output logic [AXES*WIDTH-1:0]   vel_out,
  output logic [AXES-1:0]         ovf
);

  localparam int unsigned K_W = (AXES > 1) ? $clog2(AXES) : 1;

  state_t             state;
  logic [K_W-1:0]     k;
  logic [DT_W-1:0]    dt;
  logic [WIDTH-1:0]   pos_axis [AXES];
  logic [WIDTH-1:0]   vel_axis [AXES];
  logic [WIDTH-1:0]   mac_pos_c;
  logic               mac_ovf_c;

  // Unpack the state vectors so the axis counter can select one word
  for (genvar i = 0; i < AXES; i++) begin : g_unpack
    assign pos_axis[i] = pos_out[i*WIDTH +: WIDTH];
    assign vel_axis[i] = vel_out[i*WIDTH +: WIDTH];
  end

  nav_axis_mac #(
    .WIDTH (WIDTH),
    .DT_W  (DT_W),
    .FRAC  (FRAC)
  ) u_mac (
    .pos        (pos_axis[k]),
    .vel        (vel_axis[k]),
    .dt         (dt),
    .pos_next_c (mac_pos_c),
    .ovf_c      (mac_ovf_c)
  );

  // Command FSM: accept in IDLE, one axis per CALC cycle, hold result in OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      dt        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pos_out   <= '0;
      vel_out   <= '0;
      ovf       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            vel_out  <= vel_in;
            dt       <= dt_in;
            if (cmd_set == CMD_SET) begin
              pos_out   <= pos_in;
              ovf       <= '0;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              k     <= '0;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          for (int i = 0; i < AXES; i++) begin
            if (k == K_W'(i)) begin
              pos_out[i*WIDTH +: WIDTH] <= mac_pos_c;
              ovf[i]                    <= ovf[i] | mac_ovf_c;
            end
          end
          if (k == K_W'(AXES - 1)) begin
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            k <= k + K_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nav_state_integrator.sv
// Self-checking bench for nav_state_integrator (AXES=3, WIDTH=32, DT_W=16, FRAC=8).
// Honours NAV_SAT_EN in its reference model.
module tb_nav_state_integrator;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AXES  = 3;
  localparam int unsigned DT_W  = 16;
  localparam int unsigned FRAC  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic                  cmd_set;
  logic [AXES*WIDTH-1:0] pos_in;
  logic [AXES*WIDTH-1:0] vel_in;
  logic [DT_W-1:0]       dt_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [AXES*WIDTH-1:0] pos_out;
  logic [AXES*WIDTH-1:0] vel_out;
  logic [AXES-1:0]       ovf;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int       mpos [AXES];
  int       mvel [AXES];
  bit [2:0] movf;

  nav_state_integrator #(
    .WIDTH (WIDTH), .AXES (AXES), .DT_W (DT_W), .FRAC (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_set   (cmd_set),
    .pos_in    (pos_in),
    .vel_in    (vel_in),
    .dt_in     (dt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pos_out   (pos_out),
    .vel_out   (vel_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AXES*WIDTH-1:0] pack3(input int a0, input int a1, input int a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [AXES*WIDTH-1:0] exp_pos();
    return {mpos[2], mpos[1], mpos[0]};
  endfunction

  function automatic logic [AXES*WIDTH-1:0] exp_vel();
    return {mvel[2], mvel[1], mvel[0]};
  endfunction

  // Model: SET loads position, clears overflow
  task automatic model_set(input logic [AXES*WIDTH-1:0] p, input logic [AXES*WIDTH-1:0] v);
    for (int i = 0; i < AXES; i++) begin
      mpos[i] = int'(p[i*WIDTH +: WIDTH]);
      mvel[i] = int'(v[i*WIDTH +: WIDTH]);
    end
    movf = '0;
  endtask

  // Model: PROP with exact integer arithmetic and floor division by 2^FRAC
  task automatic model_prop(input logic [AXES*WIDTH-1:0] v, input logic [DT_W-1:0] d);
    longint prod, delta, sum;
    for (int i = 0; i < AXES; i++) begin
      mvel[i] = int'(v[i*WIDTH +: WIDTH]);
      prod    = longint'(mvel[i]) * longint'({48'd0, d});
      delta   = prod >>> FRAC;
      sum     = longint'(mpos[i]) + delta;
      if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
        movf[i] = 1'b1;
`ifdef NAV_SAT_EN
        mpos[i] = (sum > 0) ? 32'sh7FFFFFFF : 32'sh80000000;
`else
        mpos[i] = int'(sum);
`endif
      end else begin
        mpos[i] = int'(sum);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < AXES; i++) begin
      mpos[i] = 0;
      mvel[i] = 0;
    end
    movf = '0;
  endtask

  // Issue one command; lat = cycles from acceptance edge to out_valid, negative on timeout
  task automatic run_cmd(input bit set, input logic [AXES*WIDTH-1:0] p,
                         input logic [AXES*WIDTH-1:0] v, input logic [DT_W-1:0] d,
                         output int lat);
    int waited;
    lat    = -1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      lat = -2;
      return;
    end
    in_valid = 1'b1;
    cmd_set  = set;
    pos_in   = p;
    vel_in   = v;
    dt_in    = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (set) model_set(p, v);
    else     model_prop(v, d);
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Consume the result after holding off for hold cycles
  task automatic pop(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tests++;
    if (pos_out !== '0 || vel_out !== '0 || ovf !== '0) begin
      fails++;
      $display("FAIL reset_state: pos=%h vel=%h ovf=%b, required all zero", pos_out, vel_out, ovf);
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_set_prop();
    int lat;
    logic [AXES*WIDTH-1:0] v;
    v = pack3(256, -512, 1);
    run_cmd(1'b1, pack3(100, -50, 0), v, 16'd0, lat);
    tests++;
    if (lat !== 1) begin
      fails++;
      $display("FAIL set_latency: got %0d, required 1", lat);
    end
    tests++;
    if (pos_out !== pack3(100, -50, 0) || ovf !== 3'b000) begin
      fails++;
      $display("FAIL set_value: pos=%h ovf=%b, required %h ovf=000", pos_out, ovf, pack3(100, -50, 0));
    end
    pop(0);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL set_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    run_cmd(1'b0, '0, v, 16'd256, lat);
    tests++;
    if (lat !== AXES + 1) begin
      fails++;
      $display("FAIL prop_latency: got %0d, required %0d", lat, AXES + 1);
    end
    tests++;
    if (pos_out !== pack3(356, -562, 1) || vel_out !== v) begin
      fails++;
      $display("FAIL prop_value: pos=%h vel=%h, required %h %h", pos_out, vel_out, pack3(356, -562, 1), v);
    end
    pop(0);
  endtask

  task automatic test_floor();
    int lat;
    run_cmd(1'b1, '0, '0, 16'd0, lat);
    pop(0);
    run_cmd(1'b0, '0, pack3(-1, 0, 0), 16'd1, lat);
    tests++;
    if (lat !== AXES + 1 || pos_out !== pack3(-1, 0, 0)) begin
      fails++;
      $display("FAIL floor_round: lat=%0d pos=%h, required lat=%0d pos=%h", lat, pos_out, AXES + 1, pack3(-1, 0, 0));
    end
    pop(0);
  endtask

  task automatic test_overflow();
    int lat;
    logic [WIDTH-1:0] want;
`ifdef NAV_SAT_EN
    want = 32'h7FFFFFFF;
`else
    want = 32'h800000F0;
`endif
    run_cmd(1'b1, pack3(32'h7FFFFFF0, 5, -5), '0, 16'd0, lat);
    pop(1);
    run_cmd(1'b0, '0, pack3(32'h100, 0, 0), 16'd256, lat);
    tests++;
    if (pos_out[WIDTH-1:0] !== want || ovf !== 3'b001) begin
      fails++;
      $display("FAIL overflow: pos0=%h ovf=%b, required %h ovf=001", pos_out[WIDTH-1:0], ovf, want);
    end
    pop(0);
    run_cmd(1'b0, '0, '0, 16'd300, lat);
    tests++;
    if (ovf !== 3'b001 || pos_out !== exp_pos()) begin
      fails++;
      $display("FAIL ovf_sticky: ovf=%b pos=%h, required 001 %h", ovf, pos_out, exp_pos());
    end
    pop(0);
    run_cmd(1'b1, '0, '0, 16'd0, lat);
    tests++;
    if (ovf !== 3'b000) begin
      fails++;
      $display("FAIL ovf_clear_on_set: ovf=%b, required 000", ovf);
    end
    pop(0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [AXES*WIDTH-1:0] held;
    run_cmd(1'b0, '0, pack3(1000, -2000, 3000), 16'd512, lat);
    held = pos_out;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      cmd_set  = 1'b1;
      pos_in   = pack3(int'($urandom), int'($urandom), int'($urandom));
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pos_out !== held) begin
        fails++;
        $display("FAIL backpressure_hold c=%0d: out_valid=%b in_ready=%b pos=%h, required 1/0 %h",
                 c, out_valid, in_ready, pos_out, held);
      end
    end
    in_valid = 1'b0;
    pop(0);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || pos_out !== exp_pos()) begin
      fails++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b pos=%h, required 0/1 %h",
               out_valid, in_ready, pos_out, exp_pos());
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    in_valid = 1'b1;
    cmd_set  = 1'b0;
    vel_in   = pack3(7000, 7000, 7000);
    dt_in    = 16'd1000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    tests++;
    if (pos_out !== '0 || vel_out !== '0 || ovf !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_calc: pos=%h vel=%h ovf=%b out_valid=%b in_ready=%b, required zeros and in_ready=1",
               pos_out, vel_out, ovf, out_valid, in_ready);
    end
    run_cmd(1'b1, pack3(11, 22, 33), pack3(1, 2, 3), 16'd0, lat);
    tests++;
    if (lat !== 1 || pos_out !== pack3(11, 22, 33) || vel_out !== pack3(1, 2, 3)) begin
      fails++;
      $display("FAIL set_after_reset: lat=%0d pos=%h vel=%h, required 1 %h %h",
               lat, pos_out, vel_out, pack3(11, 22, 33), pack3(1, 2, 3));
    end
    pop(0);
  endtask

  task automatic test_random();
    int lat;
    bit set;
    logic [AXES*WIDTH-1:0] p, v;
    logic [DT_W-1:0] d;
    for (int n = 0; n < 40; n++) begin
      set = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < AXES; i++) begin
        p[i*WIDTH +: WIDTH] = $urandom;
        if ($urandom_range(0, 1) == 1) v[i*WIDTH +: WIDTH] = $urandom;
        else v[i*WIDTH +: WIDTH] = WIDTH'(int'($urandom_range(0, 20000)) - 10000);
      end
      d = DT_W'($urandom);
      run_cmd(set, p, v, d, lat);
      tests++;
      if (lat !== (set ? 1 : AXES + 1)) begin
        fails++;
        $display("FAIL random_latency n=%0d: got %0d, required %0d", n, lat, set ? 1 : AXES + 1);
      end
      tests++;
      if (pos_out !== exp_pos() || vel_out !== exp_vel() || ovf !== movf) begin
        fails++;
        $display("FAIL random_value n=%0d: pos=%h vel=%h ovf=%b, required %h %h %b",
                 n, pos_out, vel_out, ovf, exp_pos(), exp_vel(), movf);
      end
      pop($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    cmd_set   = 1'b0;
    pos_in    = '0;
    vel_in    = '0;
    dt_in     = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_set_prop();
    test_floor();
    test_overflow();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nav_state_integrator.md
Name: nav_state_integrator

Overview:
- Parametrised successor to the registered navigation pass-through stage. Holds a per-axis position state vector and propagates it with velocity times time step: pos[i] += (vel[i]*dt) >>> FRAC.
- Processes AXES channels serially through one shared multiply-accumulate, with valid/ready handshakes on input and output.
- Sits between the measurement front end and downstream navigation consumers.

Parameters:
- WIDTH, 32: signed two's-complement width of each position and velocity word.
- AXES, 3: number of channels (axes); range 1..8.
- DT_W, 16: width of the unsigned time-step input.
- FRAC, 8: fractional bits of dt; the product is arithmetically right-shifted by FRAC.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset.
- in_valid, input, 1: input command valid.
- in_ready, output, 1: block can accept a command.
- cmd_set, input, 1: 1 = SET (load state), 0 = PROP (propagate).
- pos_in, input, AXES*WIDTH: axis i occupies bits [i*WIDTH +: WIDTH]; used on SET only.
- vel_in, input, AXES*WIDTH: velocity per axis, same packing.
- dt_in, input, DT_W: unsigned time step, Q(DT_W-FRAC).FRAC.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream accepts the result.
- pos_out, output, AXES*WIDTH: current position state.
- vel_out, output, AXES*WIDTH: velocity captured with the last command.
- ovf, output, AXES: per-axis sticky overflow flags.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n low at a rising edge):
  - pos_out, vel_out, ovf clear to 0.
  - out_valid clears to 0; FSM returns to IDLE; axis counter clears to 0.
  - Applies in any state, including mid-CALC; partial results are discarded.
- FSM states: IDLE, CALC, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid&in_ready: capture vel_in, dt_in and cmd_set.
  - SET: load pos_state from pos_in, clear ovf, go to OUT.
  - PROP: clear axis counter k, go to CALC.
- CALC:
  - in_ready = 0.
  - Each cycle updates axis k. k increments; after k = AXES-1, go to OUT.
  - Exactly AXES cycles.
- OUT:
  - out_valid = 1; pos_out and vel_out are stable while waiting.
  - On out_ready, go to IDLE next cycle; out_valid drops.
  - Backpressure holds indefinitely.
- Latency from acceptance edge to out_valid high:
  - SET: 1 cycle.
  - PROP: AXES+1 cycles.
  - Throughput: one command per AXES+2 cycles (PROP) or 2 cycles (SET). The IDLE bubble is required.
- in_ready is never high together with out_valid; no simultaneous accept/complete case exists.
- Arithmetic per axis:
  - prod = signed(vel) * signed({1'b0, dt}), WIDTH+DT_W+1 bits.
  - delta = prod >>> FRAC (floor; vel=-1, dt=1 gives -1).
  - sum = sign-extended pos + delta, WIDTH+DT_W+2 bits.
  - Out-of-range detection: sum outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] sets ovf[k], sticky until SET or reset.
  - Result handling on overflow is set by the optional feature.
- pos_out continuously reflects pos_state; it may change during CALC. Consumers sample pos_out only on out_valid&out_ready.
- in_valid while in_ready = 0 is ignored (no queueing).

Optional Feature:
- Macro NAV_SAT_EN.
  - Defined: an out-of-range sum saturates to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - Undefined: the sum truncates to its low WIDTH bits (wrap).
- ovf is set in both builds.

Decomposition:
- Package nav_pkg holds:
  - FSM state encoding (IDLE, CALC, OUT) as a typedef/localparams.
  - Command encoding constants CMD_SET / CMD_PROP.
  - Shared saturation-limit functions.
- One natural sub-module: nav_axis_mac.
  - Combinational scaled multiply, shift, add and saturate/wrap for one axis.
  - Instantiated once and time-shared by the axis counter.

Test Plan (AXES=3, WIDTH=32, DT_W=16, FRAC=8):
- SET with pos=(100,-50,0), vel=(256,-512,1) -> out_valid 1 cycle later; pos_out=(100,-50,0); ovf=0.
- Then PROP with dt=256 -> out_valid 4 cycles after acceptance; pos_out=(356,-562,1); vel_out=(256,-512,1).
- SET pos=(0,0,0), then PROP with vel=(-1,0,0), dt=1 -> pos_out=(-1,0,0) (floor rounding).
- SET pos axis0=0x7FFFFFF0, then PROP with vel axis0=0x100, dt=256 -> NAV_SAT_EN gives pos0=0x7FFFFFFF; without it pos0=0x800000F0; ovf[0]=1 in both builds, and stays 1 after a further PROP with vel=0.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, pos_out stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle.
- Drive rst_n=0 during the 2nd CALC cycle -> next edge gives all outputs 0, in_ready=1. The following SET behaves normally.
